// File: rtl/online_mult_seq.sv
// online_mult_seq: MSD-first signed-digit online multiplier, radix 2**RADIX_LOG2, online delay DELTA.
// Define ONLINE_MULT_RESIDUAL_OUT_EN to expose the residual (w_out) and a selection-saturation pulse (sel_sat).
module online_mult_seq #(
   parameter  int NO_OF_DIGITS = 8,
   parameter  int RADIX_LOG2   = 1,
   parameter  int RADIX_BITS   = 2,
   parameter  int DELTA        = 3,
   localparam int FW           = RADIX_LOG2 * (NO_OF_DIGITS + DELTA),
   localparam int WW           = 4 + RADIX_LOG2 + FW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [RADIX_BITS-1:0] x_dig,
   input  logic signed [RADIX_BITS-1:0] y_dig,
   output logic signed [RADIX_BITS-1:0] p_dig,
   output logic                         out_valid,
   output logic                         done,
   output logic                         busy
`ifdef ONLINE_MULT_RESIDUAL_OUT_EN
   ,
   output logic signed [WW-1:0]         w_out,
   output logic                         sel_sat
`endif
);
   localparam int XW = RADIX_LOG2 * NO_OF_DIGITS + 1;
   localparam int TW = XW + RADIX_BITS + 1;
   localparam int CW = $clog2(NO_OF_DIGITS + DELTA + 1);
   localparam logic [CW-1:0] LAST_IN = CW'(NO_OF_DIGITS - 1);
   localparam logic [CW-1:0] LAST    = CW'(NO_OF_DIGITS + DELTA - 1);
   localparam logic [CW-1:0] SEL_K   = CW'(DELTA);
   localparam logic signed [WW-1:0] HALF = WW'(1) <<< (FW - 1);
   localparam logic signed [WW-1:0] PMAX = WW'((1 << RADIX_LOG2) - 1);
   localparam logic signed [WW-1:0] PMIN = -PMAX;

   typedef enum logic [1:0] {IDLE, RUN_IN, RUN_FLUSH} state_t;

   state_t                       r_state;
   logic [CW-1:0]                r_cnt;
   logic signed [XW-1:0]         r_x, r_y;
   logic signed [WW-1:0]         r_w;
   int                           w_sh;
   logic                         w_step, w_sel, w_hi, w_lo;
   logic signed [RADIX_BITS-1:0] w_x, w_y;
   logic signed [XW-1:0]         w_xs, w_ys, w_yn;
   logic signed [TW-1:0]         w_term;
   logic signed [WW-1:0]         w_v, w_fl, w_p, w_wn;

   assign in_ready = r_state == RUN_IN;
   assign busy     = r_state != IDLE;
`ifdef ONLINE_MULT_RESIDUAL_OUT_EN
   assign w_out    = r_w;
`endif

   // X/Y are scaled by r^n and W by r^(n+delta), so term*r^-delta lands on W's LSB exactly
   always_comb begin
      w_step = (r_state == RUN_IN && in_valid) || r_state == RUN_FLUSH;
      w_x    = r_state == RUN_IN ? x_dig : '0;
      w_y    = r_state == RUN_IN ? y_dig : '0;
      w_sh   = r_cnt <= LAST_IN ? RADIX_LOG2 * (NO_OF_DIGITS - 1 - int'(r_cnt)) : 0;
      w_xs   = XW'(w_x) <<< w_sh;
      w_ys   = XW'(w_y) <<< w_sh;
      w_yn   = r_y + w_ys;
      w_term = TW'(r_x) * TW'(w_y) + TW'(w_yn) * TW'(w_x);
      w_v    = (r_w <<< RADIX_LOG2) + WW'(w_term);
      w_fl   = (w_v + HALF) >>> FW;
      w_hi   = w_fl > PMAX;
      w_lo   = w_fl < PMIN;
      w_p    = w_hi ? PMAX : w_lo ? PMIN : w_fl;
      w_sel  = r_cnt >= SEL_K;
      w_wn   = w_sel ? w_v - (w_p <<< FW) : w_v;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_w       <= '0;
         p_dig     <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
`ifdef ONLINE_MULT_RESIDUAL_OUT_EN
         sel_sat   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         done      <= 1'b0;
`ifdef ONLINE_MULT_RESIDUAL_OUT_EN
         sel_sat   <= 1'b0;
`endif
         if (r_state == IDLE) begin
            if (start) begin
               r_state <= RUN_IN;
               r_cnt   <= '0;
               r_x     <= '0;
               r_y     <= '0;
               r_w     <= '0;
            end
         end else if (w_step) begin
            r_cnt     <= r_cnt + CW'(1);
            r_x       <= r_x + w_xs;
            r_y       <= w_yn;
            r_w       <= w_wn;
            out_valid <= w_sel;
            if (w_sel)
               p_dig <= w_p[RADIX_BITS-1:0];
`ifdef ONLINE_MULT_RESIDUAL_OUT_EN
            sel_sat   <= w_sel && (w_hi || w_lo);
`endif
            if (r_cnt == LAST) begin
               r_state <= IDLE;
               done    <= 1'b1;
            end else if (r_state == RUN_IN && r_cnt == LAST_IN)
               r_state <= RUN_FLUSH;
         end
      end
   end
endmodule
